regfile_mp: RTL

Parametrised multi-port register file with write-through bypass and a pending-write scoreboard; next-generation replacement for the fixed 16×16 register file. It has two asynchronous read ports and two prioritised write ports: W0 for ALU writeback, W1 for load writeback. A scoreboard marks destination registers busy at instruction issue and clears them on writeback, so the decode stage can stall on RAW hazards.

---
 rtl/regfile_mp.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//
// Parametrised multi-port register file with a pending-write scoreboard.
//
// Two combinational read ports (A, B) and two write ports:
//   W0 - ALU writeback, highest priority
//   W1 - load writeback, dropped when it collides with W0 on the same register
//
// Reads see a write that happens in the same cycle. Bypass order is W0, then
// W1, then the stored value. A scoreboard keeps one busy bit per register.
// An issue sets the bit and a writeback clears it. If both hit the same
// register in one cycle, the set wins because a new producer has been issued.
// Decode can use the rdy outputs to stall on RAW hazards.
//
// Build option:
//   REGFILE_ZERO_REG_EN - register 0 is hardwired to zero. Reads of r0 return
//                         0 and report ready. Writes and issues to r0 are
//                         discarded. When undefined, r0 is an ordinary
//                         register.
//
// Parameters:
//   DATA_W  register width in bits
//   NREGS   number of registers (power of two, >= 4)
//   AW      address width, derived from NREGS; do not override
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   a_sel     read port A address     -> a_data, a_rdy
//   b_sel     read port B address     -> b_data, b_rdy
//   a_data    bypassed read data, port A
//   b_data    bypassed read data, port B
//   a_rdy     port A register has no pending write (or is written this cycle)
//   b_rdy     port B register has no pending write (or is written this cycle)
//   w0_en     write port 0 enable
//   w0_sel    write port 0 address
//   w0_data   write port 0 data
//   w1_en     write port 1 enable
//   w1_sel    write port 1 address
//   w1_data   write port 1 data
//   iss_en    issue strobe: mark iss_sel pending
//   iss_sel   destination register of the issued instruction
//   pend_cnt  registered count of pending registers
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [AW-1:0]     a_sel,
    input  logic [AW-1:0]     b_sel,
    output logic [DATA_W-1:0] a_data,
    output logic [DATA_W-1:0] b_data,
    output logic              a_rdy,
    output logic              b_rdy,

    input  logic              w0_en,
    input  logic [AW-1:0]     w0_sel,
    input  logic [DATA_W-1:0] w0_data,

    input  logic              w1_en,
    input  logic [AW-1:0]     w1_sel,
    input  logic [DATA_W-1:0] w1_data,

    input  logic              iss_en,
    input  logic [AW-1:0]     iss_sel,

    output logic [AW:0]       pend_cnt
);

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  pend;

    // -------------------------------------------------------------------------
    // Per-register decode
    // -------------------------------------------------------------------------
    logic [NREGS-1:0]  w0_dec;      // W0 targets register i
    logic [NREGS-1:0]  w1_dec;      // W1 targets register i
    logic [NREGS-1:0]  iss_dec;     // issue targets register i
    logic [NREGS-1:0]  w1_take;     // W1 actually lands (not shadowed by W0)
    logic [NREGS-1:0]  pend_next;
    logic [AW:0]       pend_cnt_next;

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_dec
        // A hardwired zero register never decodes as a target. W0 and W1
        // writes to it disappear here, so they cannot collide with anything.
        localparam bit IS_ZERO = ZERO_REG && (gi == 0);

        assign w0_dec[gi]  = !IS_ZERO && w0_en  && (w0_sel  == AW'(gi));
        assign w1_dec[gi]  = !IS_ZERO && w1_en  && (w1_sel  == AW'(gi));
        assign iss_dec[gi] = !IS_ZERO && iss_en && (iss_sel == AW'(gi));

        // W0 wins a same-register collision; W1 data is dropped.
        assign w1_take[gi] = w1_dec[gi] && !w0_dec[gi];

        // Both write ports clear the busy bit, including a W1 that lost the
        // collision, because the register was written either way. An issue in
        // the same cycle re-arms the bit for the new producer.
        assign pend_next[gi] = iss_dec[gi] |
                               (pend[gi] & ~(w0_dec[gi] | w1_dec[gi]));
    end

    // The count is taken from the next-state vector, so the registered
    // pend_cnt always agrees with pend after the same edge.
    always_comb begin
        pend_cnt_next = '0;
        for (int i = 0; i < NREGS; i++) begin
            pend_cnt_next = pend_cnt_next + (AW+1)'(pend_next[i]);
        end
    end

    // -------------------------------------------------------------------------
    // Storage, scoreboard and count registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w0_dec[i]) begin
                    regs[i] <= w0_data;
                end else if (w1_take[i]) begin
                    regs[i] <= w1_data;
                end
            end
            pend     <= pend_next;
            pend_cnt <= pend_cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Read ports (combinational, bypassed)
    // Port 0 is A and port 1 is B. The logic is identical for both ports.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic [AW-1:0]     sel;
        logic [DATA_W-1:0] data;
        logic              rdy;

        assign sel = (gi == 0) ? a_sel : b_sel;

        always_comb begin
            data = regs[sel];
            rdy  = !pend[sel];

            // Evaluate W1 first so that a W0 match overrides it. This gives
            // the W0 > W1 > storage priority. A writeback also makes the
            // register ready in the same cycle.
            if (w1_en && (w1_sel == sel)) begin
                data = w1_data;
                rdy  = 1'b1;
            end
            if (w0_en && (w0_sel == sel)) begin
                data = w0_data;
                rdy  = 1'b1;
            end

            // A hardwired zero register ignores any bypass.
            if (ZERO_REG && (sel == '0)) begin
                data = '0;
                rdy  = 1'b1;
            end

            // During reset the storage already reads 0. This also masks any
            // write-port activity on the bypass path.
            if (!rst_n) begin
                data = '0;
                rdy  = 1'b1;
            end
        end
    end

    assign a_data = g_rd[0].data;
    assign a_rdy  = g_rd[0].rdy;
    assign b_data = g_rd[1].data;
    assign b_rdy  = g_rd[1].rdy;

endmodule
